// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the seq_detect_arbiter pattern scanner.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int              DEF_PAT_W   = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b0110;

  // Width of a requester ID; never zero so a 1-requester build still has a port.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: shift window, per-frame bit counter and saturating
// overlapping-match counter. Cleared at the start of every frame.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int                FRAME_LEN = 16,
  parameter int                PAT_W     = DEF_PAT_W,
  parameter logic [PAT_W-1:0]  PATTERN   = DEF_PATTERN,
  parameter int                CNT_W     = 5,
  parameter int                BC_W      = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clear,
  input  logic             i_bit_valid,
  input  logic             i_bit_in,
  output logic [CNT_W-1:0] o_count,
  output logic             o_match,
  output logic [BC_W-1:0]  o_bits
);

  localparam logic [BC_W-1:0]  MIN_BITS = BC_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [PAT_W-1:0] r_win;
  logic [PAT_W-1:0] w_win_nxt;
  logic [BC_W-1:0]  r_bits;
  logic [BC_W-1:0]  w_bits_nxt;
  logic [CNT_W-1:0] r_cnt;

  assign w_win_nxt  = {r_win[PAT_W-2:0], i_bit_in};
  assign w_bits_nxt = r_bits + 1'b1;

  // The bit-count guard stops the zeroed window from faking a match early in a frame.
  assign o_match = i_bit_valid && (w_win_nxt == PATTERN) && (w_bits_nxt >= MIN_BITS);

  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      r_win  <= '0;
      r_bits <= '0;
      r_cnt  <= '0;
    end else if (i_bit_valid) begin
      r_win  <= w_win_nxt;
      r_bits <= w_bits_nxt;
      if (o_match && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_count = r_cnt;
  assign o_bits  = r_bits;

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin frame arbiter feeding one serial pattern matcher; reports match
// count and requester ID on a valid/ready port. Optional SEQ_MATCH_STREAM_EN
// adds match_pulse / scan_valid observation outputs.
module seq_detect_arbiter
  import seq_detect_pkg::*;
#(
  parameter int               NREQ      = 4,
  parameter int               FRAME_LEN = 16,
  parameter int               PAT_W     = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN   = DEF_PATTERN,
  parameter int               CNT_W     = 5
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*FRAME_LEN-1:0] req_frame,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [id_w(NREQ)-1:0]     res_id,
  output logic [CNT_W-1:0]          res_count
`ifdef SEQ_MATCH_STREAM_EN
  ,
  output logic                      match_pulse,
  output logic                      scan_valid
`endif
);

  localparam int ID_W = id_w(NREQ);
  localparam int BC_W = $clog2(FRAME_LEN + 1);

  state_t               r_state, w_state_nxt;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_id;
  logic [FRAME_LEN-1:0] r_frame;

  logic                 w_any;
  logic [ID_W-1:0]      w_win_id;
  logic [ID_W-1:0]      w_idx;
  logic [FRAME_LEN-1:0] w_frame_sel;
  logic                 w_grant;
  logic                 w_scan;
  logic                 w_last;
  logic                 w_match;
  logic [CNT_W-1:0]     w_count;
  logic [BC_W-1:0]      w_bits;

  // First requester strictly after the pointer, wrapping; the pointer itself is checked last.
  always_comb begin
    w_any    = 1'b0;
    w_win_id = '0;
    w_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % NREQ);
      if (!w_any && req[w_idx]) begin
        w_any    = 1'b1;
        w_win_id = w_idx;
      end
    end
  end

  always_comb begin
    w_frame_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_win_id == ID_W'(i))
        w_frame_sel = req_frame[i*FRAME_LEN +: FRAME_LEN];
  end

  assign w_grant = (r_state == ST_IDLE) && w_any;
  assign w_scan  = (r_state == ST_SCAN);
  assign w_last  = w_scan && (w_bits == BC_W'(FRAME_LEN - 1));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_any)     w_state_nxt = ST_SCAN;
      ST_SCAN:   if (w_last)    w_state_nxt = ST_REPORT;
      ST_REPORT: if (res_ready) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs; gnt is masked during reset so no frame is handed off unseen.
  always_comb begin
    gnt       = '0;
    busy      = (r_state != ST_IDLE);
    res_valid = (r_state == ST_REPORT);
    if (w_grant && rstn)
      gnt[w_win_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_frame <= '0;
      r_ptr   <= ID_W'(NREQ - 1);
      r_id    <= '0;
    end else if (w_grant) begin
      r_frame <= w_frame_sel;
      r_ptr   <= w_win_id;
      r_id    <= w_win_id;
    end else if (w_scan) begin
      r_frame <= {r_frame[FRAME_LEN-2:0], 1'b0};
    end
  end

  seq_match_core #(
    .FRAME_LEN (FRAME_LEN),
    .PAT_W     (PAT_W),
    .PATTERN   (PATTERN),
    .CNT_W     (CNT_W),
    .BC_W      (BC_W)
  ) u_core (
    .clk         (clk),
    .rstn        (rstn),
    .i_clear     (w_grant),
    .i_bit_valid (w_scan),
    .i_bit_in    (r_frame[FRAME_LEN-1]),
    .o_count     (w_count),
    .o_match     (w_match),
    .o_bits      (w_bits)
  );

  assign res_id    = r_id;
  assign res_count = w_count;

`ifdef SEQ_MATCH_STREAM_EN
  assign match_pulse = w_match;
  assign scan_valid  = w_scan;
`else
  logic w_unused;
  assign w_unused = w_match;
`endif

endmodule

// File: doc/seq_detect_arbiter.md
Name: seq_detect_arbiter

Overview:
- Time-shared serial "0110"-style pattern scanner serving NREQ requesters.
- Each requester presents a parallel FRAME_LEN-bit frame. The block grants requesters round-robin, serializes the granted frame MSB-first into one pattern matcher, and counts overlapping matches.
- It returns the match count and the granted ID through a valid/ready result port.
- Sits between frame producers and the consumer of detection statistics.

Parameters:
- NREQ, 4, number of requesters (2..8)
- FRAME_LEN, 16, bits per frame (>= PAT_W)
- PAT_W, 4, pattern length in bits
- PATTERN, 4'b0110, pattern to detect; first-received bit is the MSB
- CNT_W, 5, match-count width; must hold FRAME_LEN-PAT_W+1

Ports:
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  synchronous active-low reset
- req  in  NREQ  per-requester request; held until own gnt
- req_frame  in  NREQ*FRAME_LEN  frames; requester i occupies bits [i*FRAME_LEN +: FRAME_LEN]
- gnt  out  NREQ  one-hot, one-cycle pulse when frame i is captured
- busy  out  1  high in every state except IDLE
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_id  out  $clog2(NREQ)  requester whose frame was scanned
- res_count  out  CNT_W  number of overlapping matches in the frame

Behaviour:
- Reset (rstn=0 at a clk edge):
  - Outputs: gnt=0, busy=0, res_valid=0, res_id=0, res_count=0.
  - Internal: state=IDLE, RR pointer=NREQ-1 (so req[0] wins first), shift window cleared, bit counter=0.
  - Reset mid-SCAN or mid-REPORT aborts the operation; the frame is lost and no gnt is reissued.
- FSM states: IDLE, SCAN, REPORT.
- IDLE:
  - If any req bit is high, pick the first requester after the RR pointer, wrapping.
  - In that cycle: capture its frame, pulse its gnt, store its ID, update the RR pointer to the winner, clear count and window, go to SCAN.
  - With no requests, remain in IDLE.
- SCAN: one bit per cycle, MSB first, for exactly FRAME_LEN cycles.
  - Each cycle: window = {window[PAT_W-2:0], bit}.
  - A match is counted when window == PATTERN and at least PAT_W bits of this frame have been shifted. Overlapping matches count.
  - The window never carries bits across frames.
  - After the last bit (including any match on it), go to REPORT.
- REPORT:
  - res_valid=1, with res_id and res_count held stable.
  - When res_valid && res_ready, go to IDLE; res_valid drops the next cycle.
  - Back-to-back frames: minimum 1 IDLE cycle between REPORT and the next gnt. Latency from gnt to res_valid is FRAME_LEN+1 cycles.
- req behaviour:
  - req changes during SCAN/REPORT are ignored until IDLE.
  - A req dropped before its gnt is simply not served.
- Counter: count saturates at 2^CNT_W-1; no wrap.
- Fairness: a continuously requesting requester waits at most NREQ-1 other frames.

Optional Feature:
- SEQ_MATCH_STREAM_EN
- Defined: adds output ports match_pulse (1 bit) and scan_valid (1 bit).
  - scan_valid is high in each SCAN cycle.
  - match_pulse is high in the cycle a match is counted, registered alongside the count update.
- Undefined: ports absent; behaviour otherwise identical.

Decomposition:
- Package seq_detect_pkg:
  - FSM state enum (IDLE/SCAN/REPORT)
  - default PATTERN/PAT_W constants
  - an ID-width helper constant.
- One natural sub-module: seq_match_core.
  - Contains the shift window, the bit counter and the saturating match counter.
  - Interface: clear, bit_valid, bit_in, count, match.
- Arbiter and FSM stay in the top.

Test Plan:
- Reset then req=4'b0001, frame0=16'h6DB6 (0110110110110110) -> gnt=4'b0001 for 1 cycle; res_valid after 17 cycles; res_id=0, res_count=5.
- req=4'b1111 held, each frame=16'h6000 (one match) -> gnt order 0,1,2,3,0; every res_count=1.
- frame=16'h0000, and frame=16'hFFFF -> res_count=0 in both cases.
- res_ready held low for 10 cycles in REPORT -> res_valid, res_id and res_count stable; no new gnt until acceptance.
- rstn=0 for 1 cycle at SCAN bit 7 -> next cycle all outputs 0 and state IDLE; then req=4'b0100 -> requester 2 granted (pointer reset), with a correct fresh count.
- SEQ_MATCH_STREAM_EN defined, frame=16'h6DB6 -> match_pulse high on SCAN cycles 4, 7, 10, 13, 16 (1-based); scan_valid high for 16 cycles.
